control_sequencer: RTL and testbench

- Hardwired control unit that drives every strobe of the single-bus datapath: register select, bus-source enables, load enables, ALU op, memory Read/Write.
- Fetches an instruction, decodes opcode IR[31:27], and steps a Moore FSM through the micro-steps of each instruction class.
- Waits on the memory ready handshake and halts on HALT, on an illegal opcode or on Stop.

---
 rtl/control_sequencer_pkg.sv | 44 ++++
 rtl/control_sequencer_decode.sv | 38 +++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, ALU select codes, instruction classes and sequencer states
// for the single-bus CPU control unit.
package cpu_pkg;

  localparam int P_DATA_W  = 32;
  localparam int P_OPC_W   = 5;
  localparam int P_ALU_OPW = 4;

  localparam logic [P_OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [P_OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [P_OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [P_OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [P_OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [P_OPC_W-1:0] OP_AND  = 5'd5;
  localparam logic [P_OPC_W-1:0] OP_OR   = 5'd6;
  localparam logic [P_OPC_W-1:0] OP_SHR  = 5'd7;
  localparam logic [P_OPC_W-1:0] OP_SHL  = 5'd8;
  localparam logic [P_OPC_W-1:0] OP_ADDI = 5'd9;
  localparam logic [P_OPC_W-1:0] OP_ANDI = 5'd10;
  localparam logic [P_OPC_W-1:0] OP_ORI  = 5'd11;
  localparam logic [P_OPC_W-1:0] OP_MUL  = 5'd12;
  localparam logic [P_OPC_W-1:0] OP_DIV  = 5'd13;
  localparam logic [P_OPC_W-1:0] OP_NOP  = 5'd14;
  localparam logic [P_OPC_W-1:0] OP_HALT = 5'd15;

  localparam logic [P_ALU_OPW-1:0] ALU_NONE = 4'd0;
  localparam logic [P_ALU_OPW-1:0] ALU_ADD  = 4'd1;
  localparam logic [P_ALU_OPW-1:0] ALU_SUB  = 4'd2;
  localparam logic [P_ALU_OPW-1:0] ALU_AND  = 4'd3;
  localparam logic [P_ALU_OPW-1:0] ALU_OR   = 4'd4;
  localparam logic [P_ALU_OPW-1:0] ALU_SHR  = 4'd5;
  localparam logic [P_ALU_OPW-1:0] ALU_SHL  = 4'd6;
  localparam logic [P_ALU_OPW-1:0] ALU_MUL  = 4'd7;
  localparam logic [P_ALU_OPW-1:0] ALU_DIV  = 4'd8;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LDI, C_LD, C_ST, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
  } cls_t;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_TRD, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and the ALU
// function used in that instruction's T4 step.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W   = P_OPC_W,
  parameter int ALU_OPW = P_ALU_OPW
) (
  input  logic [OPC_W-1:0]   i_opcode,
  output cls_t               o_cls,
  output logic [ALU_OPW-1:0] o_alu_op
);

  always_comb begin
    o_cls    = C_ILLEGAL;
    o_alu_op = ALU_NONE;
    case (i_opcode)
      OP_LD:   begin o_cls = C_LD;     o_alu_op = ALU_ADD; end
      OP_LDI:  begin o_cls = C_LDI;    o_alu_op = ALU_ADD; end
      OP_ST:   begin o_cls = C_ST;     o_alu_op = ALU_ADD; end
      OP_ADD:  begin o_cls = C_RALU;   o_alu_op = ALU_ADD; end
      OP_SUB:  begin o_cls = C_RALU;   o_alu_op = ALU_SUB; end
      OP_AND:  begin o_cls = C_RALU;   o_alu_op = ALU_AND; end
      OP_OR:   begin o_cls = C_RALU;   o_alu_op = ALU_OR;  end
      OP_SHR:  begin o_cls = C_RALU;   o_alu_op = ALU_SHR; end
      OP_SHL:  begin o_cls = C_RALU;   o_alu_op = ALU_SHL; end
      OP_ADDI: begin o_cls = C_IALU;   o_alu_op = ALU_ADD; end
      OP_ANDI: begin o_cls = C_IALU;   o_alu_op = ALU_AND; end
      OP_ORI:  begin o_cls = C_IALU;   o_alu_op = ALU_OR;  end
      OP_MUL:  begin o_cls = C_MULDIV; o_alu_op = ALU_MUL; end
      OP_DIV:  begin o_cls = C_MULDIV; o_alu_op = ALU_DIV; end
      OP_NOP:  o_cls = C_NOP;
      OP_HALT: o_cls = C_HALT;
      default: o_cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetch, decode and
// per-class micro-steps, with memory-ready waits and halt handling.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W  = P_DATA_W,
  parameter int OPC_W   = P_OPC_W,
  parameter int ALU_OPW = P_ALU_OPW
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic [DATA_W-1:0]  IR,
  input  logic               mem_ready,
  input  logic               Stop,
  output logic               PCout,
  output logic               PCin,
  output logic               IncPC,
  output logic               MARin,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               HIin,
  output logic               LOin,
  output logic               Cout,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               Read,
  output logic               Write,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               Run,
  output logic               err,
  output state_t             dbg_state
);

  state_t             r_state;
  logic               r_err;
  cls_t               w_cls;
  logic [ALU_OPW-1:0] w_alu_op;
  state_t             w_fetch;
  logic               w_unused_ir;

  assign w_unused_ir = ^IR[DATA_W-OPC_W-1:0];

  ctrl_decode #(.OPC_W(OPC_W), .ALU_OPW(ALU_OPW)) u_decode (
    .i_opcode (IR[DATA_W-1 -: OPC_W]),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  // Stop is looked at on the edge that would enter T0, so T0 never shows strobes.
  assign w_fetch = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state <= S_RST;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_RST: r_state <= w_fetch;
        S_T0:  r_state <= S_T1;
        S_T1:  r_state <= S_TRD;
        S_TRD: if (mem_ready) r_state <= S_T2;
        S_T2:  r_state <= S_T3;
        S_T3: begin
          case (w_cls)
            C_NOP:     r_state <= w_fetch;
            C_HALT:    r_state <= S_HALT;
            C_ILLEGAL: begin r_state <= S_HALT; r_err <= 1'b1; end
            default:   r_state <= S_T4;
          endcase
        end
        S_T4: r_state <= S_T5;
        S_T5: r_state <= (w_cls inside {C_LD, C_ST, C_MULDIV}) ? S_T6 : w_fetch;
        S_T6: begin
          if (w_cls == C_LD) begin
            if (mem_ready) r_state <= S_T7;
          end else if (w_cls == C_ST) r_state <= S_T7;
          else r_state <= w_fetch;
        end
        S_T7: if (w_cls != C_ST || mem_ready) r_state <= w_fetch;
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
     Zhighout, HIin, LOin, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
     Read, Write} = '0;
    alu_op = '0;
    case (r_state)
      S_T0:  begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1:  begin Zlowout = 1'b1; PCin = 1'b1; end
      S_TRD: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2:  begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (w_cls)
          C_RALU, C_IALU:     begin Grb = 1'b1; Rout = 1'b1;  Yin = 1'b1; end
          C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_MULDIV:           begin Gra = 1'b1; Rout = 1'b1;  Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          C_RALU:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu_op; end
          C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu_op; end
          C_IALU, C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = w_alu_op; end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          C_RALU, C_IALU, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
          C_MULDIV:              begin Zlowout = 1'b1; LOin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run       = (r_state != S_RST) && (r_state != S_HALT);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized bench for control_sequencer: a cycle-by-cycle
// strobe model built from per-instruction micro-step tables.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        Clock, Clear, mem_ready, Stop;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic Zhighout, HIin, LOin, Cout, Gra, Grb, Grc, Rin, Rout, BAout;
  logic Read, Write, Run, err;
  logic [3:0]  alu_op;
  state_t      dbg_state;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read),
    .Write(Write), .alu_op(alu_op), .Run(Run), .err(err), .dbg_state(dbg_state)
  );

  localparam logic [27:0] B_ERR   = 28'd1 << 4;
  localparam logic [27:0] B_RUN   = 28'd1 << 5;
  localparam logic [27:0] B_WR    = 28'd1 << 6;
  localparam logic [27:0] B_RD    = 28'd1 << 7;
  localparam logic [27:0] B_BAOUT = 28'd1 << 8;
  localparam logic [27:0] B_ROUT  = 28'd1 << 9;
  localparam logic [27:0] B_RIN   = 28'd1 << 10;
  localparam logic [27:0] B_GRC   = 28'd1 << 11;
  localparam logic [27:0] B_GRB   = 28'd1 << 12;
  localparam logic [27:0] B_GRA   = 28'd1 << 13;
  localparam logic [27:0] B_COUT  = 28'd1 << 14;
  localparam logic [27:0] B_LOIN  = 28'd1 << 15;
  localparam logic [27:0] B_HIIN  = 28'd1 << 16;
  localparam logic [27:0] B_ZHI   = 28'd1 << 17;
  localparam logic [27:0] B_ZLO   = 28'd1 << 18;
  localparam logic [27:0] B_ZIN   = 28'd1 << 19;
  localparam logic [27:0] B_YIN   = 28'd1 << 20;
  localparam logic [27:0] B_IRIN  = 28'd1 << 21;
  localparam logic [27:0] B_MDROUT= 28'd1 << 22;
  localparam logic [27:0] B_MDRIN = 28'd1 << 23;
  localparam logic [27:0] B_MARIN = 28'd1 << 24;
  localparam logic [27:0] B_INCPC = 28'd1 << 25;
  localparam logic [27:0] B_PCIN  = 28'd1 << 26;
  localparam logic [27:0] B_PCOUT = 28'd1 << 27;

  logic [27:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                Zhighout, HIin, LOin, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
                Read, Write, Run, err, alu_op};

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic        stop;
    logic [27:0] vec;
  } entry_t;

  entry_t exp_q[$];
  int     tests = 0;
  int     fails = 0;
  logic [31:0] cur_ir;

  // Clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] alu_exp(input logic [4:0] opc);
    logic [3:0] a;
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd9: a = ALU_ADD;
      5'd4:         a = ALU_SUB;
      5'd5, 5'd10:  a = ALU_AND;
      5'd6, 5'd11:  a = ALU_OR;
      5'd7:         a = ALU_SHR;
      5'd8:         a = ALU_SHL;
      5'd12:        a = ALU_MUL;
      5'd13:        a = ALU_DIV;
      default:      a = ALU_NONE;
    endcase
    return {24'd0, a};
  endfunction

  // Driver / model tasks
  task automatic push(input logic [27:0] v, input logic rdy);
    entry_t e;
    e.ir = cur_ir; e.rdy = rdy; e.stop = 1'b0; e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic push_any(input logic [27:0] v);
    push(v, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input logic [27:0] v, input int w);
    for (int i = 0; i < w; i++) push(v, 1'b0);
    push(v, 1'b1);
  endtask

  task automatic push_halted(input int n, input logic [27:0] v);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      e.ir = cur_ir; e.rdy = 1'($urandom_range(0, 1));
      e.stop = 1'($urandom_range(0, 1)); e.vec = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_instr(input logic [4:0] opc, input int w1, input int w2);
    logic [27:0] a;
    cur_ir = {opc, 27'($urandom)};
    a = alu_exp(opc);
    push_any(B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN);
    push_any(B_RUN | B_ZLO | B_PCIN);
    push_wait(B_RUN | B_RD | B_MDRIN, w1);
    push_any(B_RUN | B_MDROUT | B_IRIN);
    if (opc >= 5'd3 && opc <= 5'd8) begin
      push_any(B_RUN | B_GRB | B_ROUT | B_YIN);
      push_any(B_RUN | B_GRC | B_ROUT | B_ZIN | a);
      push_any(B_RUN | B_ZLO | B_GRA | B_RIN);
    end else if (opc >= 5'd9 && opc <= 5'd11) begin
      push_any(B_RUN | B_GRB | B_ROUT | B_YIN);
      push_any(B_RUN | B_COUT | B_ZIN | a);
      push_any(B_RUN | B_ZLO | B_GRA | B_RIN);
    end else if (opc <= 5'd2) begin
      push_any(B_RUN | B_GRB | B_BAOUT | B_YIN);
      push_any(B_RUN | B_COUT | B_ZIN | a);
      if (opc == 5'd1) push_any(B_RUN | B_ZLO | B_GRA | B_RIN);
      else if (opc == 5'd0) begin
        push_any(B_RUN | B_ZLO | B_MARIN);
        push_wait(B_RUN | B_RD | B_MDRIN, w2);
        push_any(B_RUN | B_MDROUT | B_GRA | B_RIN);
      end else begin
        push_any(B_RUN | B_ZLO | B_MARIN);
        push_any(B_RUN | B_GRA | B_ROUT | B_MDRIN);
        push_wait(B_RUN | B_WR, w2);
      end
    end else if (opc == 5'd12 || opc == 5'd13) begin
      push_any(B_RUN | B_GRA | B_ROUT | B_YIN);
      push_any(B_RUN | B_GRB | B_ROUT | B_ZIN | a);
      push_any(B_RUN | B_ZLO | B_LOIN);
      push_any(B_RUN | B_ZHI | B_HIIN);
    end else if (opc == 5'd14) begin
      push_any(B_RUN);
    end else if (opc == 5'd15) begin
      push_any(B_RUN);
      push_halted(4, 28'd0);
    end else begin
      push_any(B_RUN);
      push_halted(4, B_ERR);
    end
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [27:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drain_n(input string tag, input int n);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      @(negedge Clock);
      check($sformatf("%s[%0d]", tag, i), e.vec);
      tests++;
      assert ((Read & Write) === 1'b0) else begin
        fails++;
        $error("FAIL %s_rdwr[%0d] observed Read=%b Write=%b expected not both", tag, i, Read, Write);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic drain_all(input string tag);
    drain_n(tag, exp_q.size());
  endtask

  // Entered at posedge+1; asserts Clear mid-cycle and leaves the FSM in T0.
  task automatic do_clear(input string tag);
    #2 Clear = 1'b1;
    #1 check({tag, "_async"}, 28'd0);
    @(posedge Clock); #1;
    check({tag, "_hold"}, 28'd0);
    Clear = 1'b0; Stop = 1'b0;
    @(posedge Clock); #1;
  endtask

  initial begin
    Clear = 1'b1; IR = '0; mem_ready = 1'b0; Stop = 1'b0; cur_ir = '0;
    @(posedge Clock); #1;
    check("reset", 28'd0);
    @(posedge Clock); #1;
    check("reset_hold", 28'd0);
    Clear = 1'b0;
    @(posedge Clock); #1;

    model_instr(5'd3, 0, 0);   drain_all("add");
    model_instr(5'd14, 3, 0);  drain_all("nop_wait3");
    model_instr(5'd0, 2, 2);   drain_all("ld");
    model_instr(5'd2, 2, 2);   drain_all("st");
    model_instr(5'd12, 0, 0);  drain_all("mul");
    model_instr(5'd13, 1, 0);  drain_all("div");
    model_instr(5'd1, 0, 0);   drain_all("ldi");
    model_instr(5'd10, 0, 0);  drain_all("andi");

    for (int k = 0; k < 30; k++) begin
      model_instr(5'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 3));
      drain_all("rand");
    end

    // Stop raised on the edge that would begin the next fetch
    model_instr(5'd14, 0, 0);
    exp_q[exp_q.size()-1].stop = 1'b1;
    push_halted(3, 28'd0);
    drain_all("stop");
    do_clear("clr_stop");

    model_instr(5'd3, 3, 0);
    drain_n("pre_clr_trd", 5);
    exp_q.delete();
    do_clear("clr_trd");

    model_instr(5'd2, 0, 3);
    drain_n("pre_clr_t7", 9);
    exp_q.delete();
    do_clear("clr_t7");

    model_instr(5'd15, 1, 0);  drain_all("halt");
    do_clear("clr_halt");

    model_instr(5'd31, 0, 0);  drain_all("illegal31");
    do_clear("clr_err");

    model_instr(5'($urandom_range(16, 30)), 0, 0);  drain_all("illegal_rand");
    do_clear("clr_err2");

    model_instr(5'd4, 1, 0);   drain_all("sub_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
